attack_envelope: RTL
====================

// Module: attack_envelope
// PURPOSE
//  Rising-amplitude counterpart to the decaying dynamics stage. It sits between the sample
//  generator and the codec path and ramps each note's gain from 0 to full in eighths.
//  Gain is applied to signed 16-bit samples. Step timing is derived from new_frame ticks
//  and the note's note_duration code.
//  Notes start silent, rise, then hold until the note ends.
// PARAMETERS
//  STEP_FRAMES_PER_UNIT  4   frames per gain step per note_duration unit (step_len = note_duration*this)
//  CNT_W                 12  width of frame step counter; must hold 63*STEP_FRAMES_PER_UNIT
// PORTS
//  clk               in   1   system clock
//  reset             in   1   asynchronous, active-low reset
//  note_duration     in   6   duration code of current note, sampled on note_start
//  note_start        in   1   1-cycle strobe: new note begins
//  done_with_note    in   1   level: note finished; forces gain path off
//  new_frame         in   1   1-cycle frame tick (48 kHz)
//  new_sample_ready  in   1   1-cycle strobe: sample_in valid
//  sample_in         in   16  signed input sample
//  final_sample      out  16  signed scaled sample, registered
//  sample_valid      out  1   1-cycle strobe: final_sample updated
//  gain              out  4   current gain in eighths (0..8), for debug/LEDs
// BEHAVIOUR
//  Reset: state=IDLE, gain=0, counter=0, final_sample=0, sample_valid=0; asserting reset mid-note
//   clears everything on the next evaluation and does not wait for a clock edge.
//  States:
//   IDLE    gain=0. note_start -> ATTACK.
//   ATTACK  counter counts new_frame ticks; at step_len ticks: gain+=1, counter=0.
//           Goes to SUSTAIN when gain reaches 8.
//   SUSTAIN gain=8 held.
//   Any state: done_with_note=1 -> IDLE, gain=0 next cycle.
//  Step length: step_len = latched note_duration*STEP_FRAMES_PER_UNIT.
//   If note_duration=0, note_start goes directly to SUSTAIN with gain=8.
//  Priority: note_start > done_with_note. A note_start in ATTACK/SUSTAIN restarts with gain=0,
//   counter=0, and re-latches note_duration.
//  Datapath: on new_sample_ready, final_sample <= (sample_in * gain) >>> 3 (signed 20-bit product).
//   Shift is arithmetic and floors toward -inf. Result is the low 16 bits; no overflow since gain<=8.
//  Latency: 1 cycle; sample_valid pulses the cycle after new_sample_ready.
//   final_sample holds between strobes.
//  Same-cycle new_sample_ready and gain step: the sample uses the pre-step gain.
//   The new gain applies from the next sample.
//  new_frame ignored in IDLE/SUSTAIN. Counter never wraps; it clears at step_len.
// CONFIGURATION
//  ATTACK_RELEASE_EN defined: done_with_note enters RELEASE instead of IDLE.
//   In RELEASE, gain-=1 every step_len frames; IDLE at gain=0.
//   note_start during RELEASE restarts ATTACK from gain=0.
//  Not defined: no RELEASE state; done_with_note zeroes gain in 1 cycle.
// STRUCTURE
//  Shared package dynamics_pkg: GAIN_W=4, GAIN_FULL=8, GAIN_SHIFT=3, state encodings
//   (IDLE, ATTACK, SUSTAIN, RELEASE), SAMPLE_W=16.
//  Sub-module step_timer: counts new_frame ticks against step_len, emits step pulse, clear input.
//  Top holds the FSM, gain register and output multiply register.
// TESTING (note_duration=3, STEP_FRAMES_PER_UNIT=4 -> step every 12 frames)
//  1. Drive note_start, then sample_in=10400 every frame. Required final_sample sequence:
//     - 0 until frame 12
//     - then 1300
//     - after frame 24: 2600
//     - after frame 96: 10400 held; state SUSTAIN.
//  2. Drive sample_in=-10400 with the same stimulus. Required final_sample after 36 frames: -3900.
//     After 96 frames: -10400.
//  3. Rounding: gain=1 with sample_in=7 -> 0; with sample_in=-7 -> -1.
//     With note_duration=0: sample 5 -> 5 immediately.
//  4. Raise done_with_note at gain=3. Required response without the macro: gain=0 next cycle,
//     and next sample out=0. Then note_start with done_with_note still high -> ATTACK from 0.
//  5. Assert reset low mid-ATTACK at gain=5. Required response: outputs 0 without a clock edge.
//     After release, sample_valid stays 0 until the next new_sample_ready.
//  6. With ATTACK_RELEASE_EN: done at gain=8, sample 10400. Required final_sample sequence:
//     - 9100 after 12 frames
//     - 0 after 96 frames
//     - state IDLE.

Source files
------------

// File: rtl/dynamics_pkg.sv
// Shared constants and state encoding for the envelope/dynamics stages.
package dynamics_pkg;

   localparam int GAIN_W     = 4;
   localparam int GAIN_SHIFT = 3;
   localparam int SAMPLE_W   = 16;
   localparam int PROD_W     = 20;

   localparam logic [GAIN_W-1:0] GAIN_FULL = 4'd8;
   localparam logic [GAIN_W-1:0] GAIN_ONE  = 4'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

endpackage

// File: rtl/step_timer.sv
// Counts frame ticks while enabled and emits a one-cycle step when step_len ticks
// have been seen; the count then restarts from zero.
module step_timer #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clear,
   input  logic             enable,
   input  logic             tick,
   input  logic [CNT_W-1:0] step_len,
   output logic             step
);

   logic [CNT_W-1:0] count;

   // A zero step_len never fires; the caller handles that case directly.
   assign step = enable && tick && (step_len != '0) && (count == step_len - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (clear || step) begin
         count <= '0;
      end else if (enable && tick) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/attack_envelope.sv
// Attack envelope: ramps note gain 0..8 in eighths and scales signed samples.
// Optional RELEASE ramp-down is enabled with the ATTACK_RELEASE_EN macro.
//
// state   | meaning
// IDLE    | no note, gain 0
// ATTACK  | gain rising one eighth every step_len frames
// SUSTAIN | gain held at full (8)
// RELEASE | gain falling one eighth every step_len frames (ATTACK_RELEASE_EN only)
module attack_envelope
   import dynamics_pkg::*;
#(
   parameter int STEP_FRAMES_PER_UNIT = 4,
   parameter int CNT_W                = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          note_duration,
   input  logic                note_start,
   input  logic                done_with_note,
   input  logic                new_frame,
   input  logic                new_sample_ready,
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic [SAMPLE_W-1:0] final_sample,
   output logic                sample_valid,
   output logic [GAIN_W-1:0]   gain
);

   env_state_t                 state;
   logic [CNT_W-1:0]           step_len;
   logic [CNT_W-1:0]           note_len;
   logic                       step;
   logic                       timer_clear;
   logic                       timer_en;
   logic signed [PROD_W-1:0]   samp_ext;
   logic signed [PROD_W-1:0]   gain_ext;
   logic signed [PROD_W-1:0]   prod;

   assign note_len = CNT_W'(note_duration) * CNT_W'(STEP_FRAMES_PER_UNIT);
   assign timer_en = (state == ATTACK) || (state == RELEASE);

`ifdef ATTACK_RELEASE_EN
   assign timer_clear = note_start || (done_with_note && (state != RELEASE));
`else
   assign timer_clear = note_start || done_with_note;
`endif

   step_timer #(.CNT_W(CNT_W)) u_step_timer (
      .clk      (clk),
      .rst_b    (reset),
      .clear    (timer_clear),
      .enable   (timer_en),
      .tick     (new_frame),
      .step_len (step_len),
      .step     (step)
   );

   // Product uses the gain register as it stands, so a same-cycle step applies to the next sample.
   assign samp_ext = PROD_W'(signed'(sample_in));
   assign gain_ext = PROD_W'(gain);
   assign prod     = samp_ext * gain_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         gain         <= '0;
         step_len     <= '0;
         final_sample <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= new_sample_ready;
         if (new_sample_ready) begin
            final_sample <= SAMPLE_W'(prod >>> GAIN_SHIFT);
         end

         if (note_start) begin
            step_len <= note_len;
            if (note_duration == 6'd0) begin
               state <= SUSTAIN;
               gain  <= GAIN_FULL;
            end else begin
               state <= ATTACK;
               gain  <= '0;
            end
         end else if (done_with_note && (state != RELEASE)) begin
`ifdef ATTACK_RELEASE_EN
            // Nothing to ramp down from, or no step timing: drop straight to silence.
            if ((state == IDLE) || (gain == '0) || (step_len == '0)) begin
               state <= IDLE;
               gain  <= '0;
            end else begin
               state <= RELEASE;
            end
`else
            state <= IDLE;
            gain  <= '0;
`endif
         end else begin
            case (state)
               ATTACK: begin
                  if (step) begin
                     gain <= gain + GAIN_ONE;
                     if (gain == GAIN_FULL - GAIN_ONE) state <= SUSTAIN;
                  end
               end
               RELEASE: begin
                  if (step) begin
                     gain <= gain - GAIN_ONE;
                     if (gain == GAIN_ONE) state <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
